lsu_pipe: RTL

Parametrised, handshaked load/store unit that replaces the combinational byte-lane LSU. It accepts one access at a time from the execute stage and drives a valid/ready memory request bus with word-aligned addresses and byte masks. It returns sign- or zero-extended load data through a one-cycle response pulse. Supports XLEN 32 or 64 (adds LD/LWU/SD) and optionally splits misaligned accesses into two bus beats.

---
 rtl/lsu_pipe.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_pipe.sv
// lsu_pipe: handshaked load/store unit. Accepts one access at a time from the
// execute stage, issues word-aligned valid/ready bus beats with byte masks and
// returns extended load data through a one-cycle response pulse.
// Optional build macro LSU_MISALIGN_SPLIT_EN: when defined, misaligned accesses
// are issued as one beat, or two beats when they cross a word boundary; when
// undefined, misaligned accesses complete immediately with resp_err and never
// touch the bus.
module lsu_pipe #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [3:0]        req_op,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_write,
    output logic [XLEN/8-1:0] mem_we,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ0 = 3'd1,
        S_RSP0 = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
        S_REQ1 = 3'd3,
        S_RSP1 = 3'd4,
`endif
        S_DONE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              err_q, err_d;

    // Incoming request classification (done on the live request in IDLE)
    logic              in_illegal;
`ifndef LSU_MISALIGN_SPLIT_EN
    logic [OW-1:0]     in_amask;
    logic              in_misaligned;
`endif

    // Classify the access presented in IDLE before it is latched
    always_comb begin
        in_illegal = (req_op[3] && req_op[2]) || ((XLEN == 32) && (req_op[1:0] == 2'd3));
`ifndef LSU_MISALIGN_SPLIT_EN
        in_amask      = OW'((4'd1 << req_op[1:0]) - 4'd1);
        in_misaligned = |(req_addr[OW-1:0] & in_amask);
`endif
    end

    // Geometry of the latched access: lane offset, byte span over two words
    logic [OW-1:0]     off;
    logic [7:0]        size_mask;
    logic [2*NB-1:0]   we_span;
    logic [2*XLEN-1:0] wd_span;
    logic [XLEN-1:0]   base_addr;

    // Byte-enable and store-data spans cover beat0 (low half) and beat1 (high half)
    always_comb begin
        off = addr_q[OW-1:0];
        case (op_q[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        we_span   = ((2*NB)'(size_mask)) << off;
        wd_span   = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
        base_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    logic              need_beat1;
    logic [OW+3:0]     beat1_shift;

    // Second beat exists only when the byte span spills past the word end
    always_comb begin
        need_beat1  = |we_span[2*NB-1:NB];
        beat1_shift = (OW+4)'(XLEN) - (OW+4)'({off, 3'b000});
    end
`else
    // Without splitting, an accepted access never crosses a word, so the
    // upper halves of the spans are always zero and intentionally unused.
    logic unused_hi;
    assign unused_hi = ^{we_span[2*NB-1:NB], wd_span[2*XLEN-1:XLEN]};
`endif

    // Load result extension from 8<<size bits, signed unless op[2] is set
    logic [6:0]        ext_bits;
    logic [XLEN-1:0]   ext_mask;
    logic [XLEN-1:0]   ext_top;
    logic              ext_neg;
    logic [XLEN-1:0]   load_ext;

    // Build the width mask and its top bit without a variable bit index
    always_comb begin
        ext_bits = 7'd8 << op_q[1:0];
        ext_mask = ~({XLEN{1'b1}} << ext_bits);
        ext_top  = ext_mask & ~(ext_mask >> 1);
        ext_neg  = !op_q[2] && (|(data_q & ext_top));
        load_ext = ext_neg ? (data_q | ~ext_mask) : (data_q & ext_mask);
    end

    // Next-state logic and capture of request fields / response data
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    op_d    = req_op;
                    data_d  = '0;
                    err_d   = 1'b0;
                    if (in_illegal) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
`ifndef LSU_MISALIGN_SPLIT_EN
                    else if (in_misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                    else begin
                        state_d = S_REQ0;
                    end
                end
            end
            S_REQ0: begin
                if (mem_req_ready) state_d = S_RSP0;
            end
            S_RSP0: begin
                if (mem_rsp_valid) begin
                    data_d = mem_rsp_rdata >> {off, 3'b000};
                    if (mem_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
`ifdef LSU_MISALIGN_SPLIT_EN
                    else if (need_beat1) begin
                        state_d = S_REQ1;
                    end
`endif
                    else begin
                        state_d = S_DONE;
                    end
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_REQ1: begin
                if (mem_req_ready) state_d = S_RSP1;
            end
            S_RSP1: begin
                if (mem_rsp_valid) begin
                    data_d  = data_q | (mem_rsp_rdata << beat1_shift);
                    err_d   = mem_rsp_err;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: bus beat fields are held stable from latched state
    always_comb begin
        req_ready     = (state_q == S_IDLE);
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_write     = 1'b0;
        mem_we        = '0;
        mem_wdata     = '0;
        case (state_q)
            S_REQ0: begin
                mem_req_valid = 1'b1;
                mem_addr      = base_addr;
                mem_write     = op_q[3];
                if (op_q[3]) begin
                    mem_we    = we_span[NB-1:0];
                    mem_wdata = wd_span[XLEN-1:0];
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_REQ1: begin
                mem_req_valid = 1'b1;
                mem_addr      = base_addr + XLEN'(NB);
                mem_write     = op_q[3];
                if (op_q[3]) begin
                    mem_we    = we_span[2*NB-1:NB];
                    mem_wdata = wd_span[2*XLEN-1:XLEN];
                end
            end
`endif
            default: ;
        endcase
        resp_valid = (state_q == S_DONE);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !op_q[3]) ? load_ext : '0;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule
